// File: rtl/axis_frame_rr_arbiter.sv
// Frame-aware round-robin arbiter: locks one AXI-Stream source per frame and
// feeds its beats through a single-entry output register, counting frames.
module axis_frame_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*DATA_W-1:0]   s_data,
    input  logic [NUM_SRC-1:0]          s_valid,
    input  logic [NUM_SRC-1:0]          s_last,
    output logic [NUM_SRC-1:0]          s_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic [2:0]                  grant,
    output logic                        busy,
    output logic [CNT_W-1:0]            frame_cnt,
    output logic                        dbg_state
);

    // Handshake: a beat moves on a rising edge where valid and ready are both
    // high; ready may depend combinationally on downstream m_ready.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_SRC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_grant;
    logic [2:0]          w_grant_nxt;
    logic [2:0]          r_last_grant;
    logic [2:0]          w_sel;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_valid;
    logic                r_m_last;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [NUM_SRC-1:0]  w_s_ready;
    logic                w_g_valid;
    logic                w_g_last;
    logic [DATA_W-1:0]   w_g_data;
    logic                w_out_free;
    logic                w_accept;

    assign w_out_free = !r_m_valid || m_ready;

    always_comb begin : p_next
        int v_dist;
        int v_best;
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_s_ready   = '0;
        w_g_valid   = 1'b0;
        w_g_last    = 1'b0;
        w_g_data    = '0;
        w_sel       = '0;
        v_best      = NUM_SRC;
        v_dist      = 0;

        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == 3'(i)) begin
                w_g_valid    = s_valid[i];
                w_g_last     = s_last[i];
                w_g_data     = s_data[i*DATA_W +: DATA_W];
                w_s_ready[i] = (r_state == ST_LOCKED) && w_out_free;
            end
        end

        // Rotating priority: distance of each requester past the last winner.
        for (int j = 0; j < NUM_SRC; j++) begin
            v_dist = j - int'(r_last_grant) - 1;
            if (v_dist < 0) v_dist = v_dist + NUM_SRC;
            if (s_valid[j] && (v_dist < v_best)) begin
                v_best = v_dist;
                w_sel  = 3'(j);
            end
        end

        w_accept = (r_state == ST_LOCKED) && w_g_valid && w_out_free;

        case (r_state)
            ST_IDLE: begin
                if (|s_valid) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = w_sel;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_g_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= LAST_IDX;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_accept) begin
                r_m_data  <= w_g_data;
                r_m_last  <= w_g_last;
                r_m_valid <= 1'b1;
                if (w_g_last) begin
                    r_frame_cnt  <= r_frame_cnt + 1'b1;
                    r_last_grant <= r_grant;
                end
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_ready   = w_s_ready;
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign m_last    = r_m_last;
    assign grant     = r_grant;
    assign busy      = (r_state == ST_LOCKED);
    assign frame_cnt = r_frame_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Bench for axis_frame_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model and an output beat scoreboard.
module tb_axis_frame_rr_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int CW = 5;

    logic             clk;
    logic             reset;
    logic [NS*DW-1:0] s_data;
    logic [NS-1:0]    s_valid;
    logic [NS-1:0]    s_last;
    logic [NS-1:0]    s_ready;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic [2:0]       grant;
    logic             busy;
    logic [CW-1:0]    frame_cnt;
    logic             dbg_state;

    axis_frame_rr_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .grant(grant), .busy(busy), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- source stream state ----------------
    int        src_pos[NS];
    int        src_len[NS];
    logic [7:0] src_base[NS];
    int        frames_left[NS];
    bit        gate[NS];
    bit        rnd_valid;
    bit        rnd_ready;

    // ---------------- reference model ----------------
    bit        mdl_busy;
    int        mdl_grant;
    int        mdl_lg;
    bit        mdl_ov;
    logic [7:0] mdl_od;
    bit        mdl_ol;
    int        mdl_cnt;
    logic [8:0] exp_q[$];

    function automatic void mdl_reset();
        mdl_busy  = 0;
        mdl_grant = 0;
        mdl_lg    = NS - 1;
        mdl_ov    = 0;
        mdl_od    = 8'h00;
        mdl_ol    = 0;
        mdl_cnt   = 0;
        exp_q.delete();
    endfunction

    function automatic logic [NS-1:0] mdl_ready();
        logic [NS-1:0] r;
        r = '0;
        if (mdl_busy && (!mdl_ov || m_ready)) r[mdl_grant] = 1'b1;
        return r;
    endfunction

    function automatic void src_frame_done(input int i);
        src_pos[i] = 0;
        if (frames_left[i] > 0) frames_left[i]--;
        if (rnd_valid) begin
            src_len[i]  = $urandom_range(1, 4);
            src_base[i] = 8'($urandom_range(0, 255));
        end
    endfunction

    // One clock edge of the arbiter described in transaction terms.
    function automatic void mdl_step();
        bit acc;
        logic [7:0] d;
        bit l;
        acc = mdl_busy && s_valid[mdl_grant] && (!mdl_ov || m_ready);
        if (!mdl_busy) begin
            for (int k = 1; k <= NS; k++) begin
                int idx;
                idx = (mdl_lg + k) % NS;
                if (!mdl_busy && s_valid[idx]) begin
                    mdl_busy  = 1;
                    mdl_grant = idx;
                end
            end
        end else if (acc) begin
            d = s_data[mdl_grant*DW +: DW];
            l = s_last[mdl_grant];
            exp_q.push_back({l, d});
            mdl_od = d;
            mdl_ol = l;
            src_pos[mdl_grant]++;
            if (l) begin
                mdl_cnt  = (mdl_cnt + 1) % 32;
                mdl_lg   = mdl_grant;
                mdl_busy = 0;
                src_frame_done(mdl_grant);
            end
        end
        if (acc) mdl_ov = 1;
        else if (mdl_ov && m_ready) mdl_ov = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            s_data[i*DW +: DW] = src_base[i] + 8'(src_pos[i]);
            s_last[i]  = (src_pos[i] == src_len[i] - 1);
            s_valid[i] = (frames_left[i] > 0) && gate[i] &&
                         (!rnd_valid || ($urandom_range(0, 3) != 0));
        end
        if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_regs();
        check("m_valid", 32'(m_valid), 32'(mdl_ov));
        check("m_data", 32'(m_data), 32'(mdl_od));
        check("m_last", 32'(m_last), 32'(mdl_ol));
        check("busy", 32'(busy), 32'(mdl_busy));
        check("dbg_state", 32'(dbg_state), 32'(mdl_busy));
        check("frame_cnt", 32'(frame_cnt), 32'(mdl_cnt));
        if (mdl_busy) check("grant", 32'(grant), 32'(mdl_grant));
    endtask

    task automatic cycle();
        logic [8:0] beat;
        drive_inputs();
        #1;
        check("s_ready", 32'(s_ready), 32'(mdl_ready()));
        if (mdl_ov && m_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(1), 32'(0));
            end else begin
                beat = exp_q.pop_front();
                check("sb_beat", 32'({m_last, m_data}), 32'(beat));
            end
        end
        @(posedge clk);
        mdl_step();
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        mdl_reset();
        for (int i = 0; i < NS; i++) src_pos[i] = 0;
        check_regs();
        check("rst_s_ready", 32'(s_ready), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        bit pending;
        n = 0;
        pending = 1;
        while (pending && n < budget) begin
            cycle();
            n++;
            pending = mdl_busy || mdl_ov;
            for (int i = 0; i < NS; i++) if (frames_left[i] > 0) pending = 1;
        end
        if (pending) check("timeout", 32'(1), 32'(0));
    endtask

    task automatic set_src(input int i, input int len, input logic [7:0] base, input int frames);
        src_len[i]     = len;
        src_base[i]    = base;
        src_pos[i]     = 0;
        frames_left[i] = frames;
        gate[i]        = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        s_data  = '0;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b1;
        rnd_valid = 0;
        rnd_ready = 0;
        for (int i = 0; i < NS; i++) set_src(i, 1, 8'h00, 0);
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        check_regs();
        check("rst_s_ready", 32'(s_ready), 32'(0));
        reset = 1'b0;
        for (int c = 0; c < 2; c++) cycle();

        // Source 1 three-beat frame A1..A3.
        set_src(1, 3, 8'hA1, 1);
        run_until_done(20);
        check("frame1_cnt", 32'(frame_cnt), 32'(1));

        // Fairness: sources 0..2 hold single-beat frames.
        set_src(0, 1, 8'h10, 4);
        set_src(1, 1, 8'h20, 4);
        set_src(2, 1, 8'h30, 4);
        run_until_done(60);

        // Source 2 locked, source 0 arrives mid-frame, source 2 stalls.
        set_src(2, 5, 8'h40, 1);
        for (int c = 0; c < 40; c++) begin
            if (c == 2) set_src(0, 1, 8'h50, 1);
            gate[2] = !(c >= 3 && c <= 5);
            cycle();
        end
        run_until_done(10);

        // Backpressure holding 0x5C for four cycles.
        set_src(3, 3, 8'h5A, 1);
        set_src(1, 2, 8'h60, 1);
        begin
            int stall;
            stall = 0;
            for (int c = 0; c < 30; c++) begin
                if (mdl_ov && mdl_od == 8'h5C && stall < 4) begin
                    m_ready = 1'b0;
                    stall++;
                end else begin
                    m_ready = 1'b1;
                end
                cycle();
            end
            check("bp_stalls", 32'(stall), 32'(4));
        end
        m_ready = 1'b1;

        // Counter wrap: reset the count first, then 31 and 32 frames.
        apply_reset();
        set_src(0, 1, 8'h70, 31);
        run_until_done(200);
        check("cnt_31", 32'(frame_cnt), 32'(31));
        set_src(0, 1, 8'h90, 1);
        run_until_done(20);
        check("cnt_wrap", 32'(frame_cnt), 32'(0));

        // Randomized traffic with random backpressure.
        rnd_valid = 1;
        rnd_ready = 1;
        for (int i = 0; i < NS; i++)
            set_src(i, $urandom_range(1, 4), 8'($urandom_range(0, 255)), $urandom_range(5, 15));
        run_until_done(3000);
        rnd_valid = 0;
        rnd_ready = 0;
        m_ready = 1'b1;

        // Reset after two of four beats, then contention from 0 and 2.
        apply_reset();
        set_src(3, 4, 8'hC0, 1);
        begin
            int n;
            n = 0;
            while (src_pos[3] < 2 && n < 20) begin
                cycle();
                n++;
            end
            check("pre_rst_beats", 32'(src_pos[3]), 32'(2));
        end
        apply_reset();
        check("rst_cnt_kept0", 32'(frame_cnt), 32'(0));
        frames_left[3] = 0;
        set_src(2, 1, 8'hD2, 1);
        set_src(0, 1, 8'hD0, 1);
        cycle();
        check("post_rst_grant0", 32'(grant), 32'(0));
        run_until_done(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
